// File: rtl/bus_arbiter2.sv
// Two-master round-robin bus arbiter placed in front of the BUS master port.
// M0 (CPU side) and M1 (DMA side) share one port. The owner keeps the grant while it
// requests, but a hold counter forces a handover when the other master is starved.
module bus_arbiter2 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_dout,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_dout,
    input  logic [DW-1:0] bus_din,
    output logic          m0_grant,
    output logic          m1_grant,
    output logic          bus_req,
    output logic          bus_wr,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_dout,
    output logic [DW-1:0] m_din
);

    // Counter only needs to reach MAX_HOLD-1; keep at least one bit when preemption is off.
    localparam int unsigned CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned HoldLast = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HoldLast);

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1
    } state_e;

    state_e        state_q, state_d;
    logic          last_owner_q, last_owner_d;  // 0 = M0, 1 = M1
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          other_req;
    logic          hold_expired;

    // Next-state, round-robin bookkeeping and starvation counter.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        other_req    = 1'b0;
        hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

        unique case (state_q)
            StIdle: begin
                if (m0_req && m1_req) begin
                    state_d = last_owner_q ? StGnt0 : StGnt1;
                end else if (m0_req) begin
                    state_d = StGnt0;
                end else if (m1_req) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                other_req = m1_req;
                if (!m0_req) begin
                    state_d = m1_req ? StGnt1 : StIdle;
                end else if (m1_req && hold_expired) begin
                    state_d = StGnt1;
                end
            end
            StGnt1: begin
                other_req = m0_req;
                if (!m1_req) begin
                    state_d = m0_req ? StGnt0 : StIdle;
                end else if (m0_req && hold_expired) begin
                    state_d = StGnt0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Remember who just gave up the bus so the next tie goes the other way.
        if (state_q == StGnt0 && state_d != StGnt0) begin
            last_owner_d = 1'b0;
        end else if (state_q == StGnt1 && state_d != StGnt1) begin
            last_owner_d = 1'b1;
        end

        // Count only cycles where the other master is left waiting; saturate at the limit.
        if (state_d != state_q || !other_req) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + CW'(1);
        end
    end

    // Arbiter FSM with registered grants; reset drops grants immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
            m0_grant     <= 1'b0;
            m1_grant     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            m0_grant     <= (state_d == StGnt0);
            m1_grant     <= (state_d == StGnt1);
        end
    end

    // Route the owner's request fields to the BUS port; idle drives zeros.
    always_comb begin
        bus_req  = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = '0;
        bus_dout = '0;
        unique case (state_q)
            StGnt0: begin
                bus_req  = m0_req;
                bus_wr   = m0_wr;
                bus_addr = m0_addr;
                bus_dout = m0_dout;
            end
            StGnt1: begin
                bus_req  = m1_req;
                bus_wr   = m1_wr;
                bus_addr = m1_addr;
                bus_dout = m1_dout;
            end
            default: ;
        endcase
    end

    // Read data goes to both masters; each one qualifies it with its own grant.
    assign m_din = bus_din;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: three instances (MAX_HOLD = 8, 4, 0) share one
// stimulus stream and are compared against a per-instance behavioural model.
module tb_bus_arbiter2;

    localparam int AW = 16;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_dout, m1_dout, bus_din;

    logic [2:0]    g0, g1, breq, bwr;
    logic [AW-1:0] baddr [3];
    logic [DW-1:0] bdout [3];
    logic [DW-1:0] mdin  [3];

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner -1 = none, 0 = M0, 1 = M1; wait_cnt = cycles the other master has
    // been kept waiting during the current grant.
    int owner    [3];
    int last     [3];
    int wait_cnt [3];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        bus_arbiter2 #(
            .MAX_HOLD((i == 0) ? 8 : (i == 1) ? 4 : 0),
            .AW      (AW),
            .DW      (DW)
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .m0_req  (m0_req),
            .m0_wr   (m0_wr),
            .m0_addr (m0_addr),
            .m0_dout (m0_dout),
            .m1_req  (m1_req),
            .m1_wr   (m1_wr),
            .m1_addr (m1_addr),
            .m1_dout (m1_dout),
            .bus_din (bus_din),
            .m0_grant(g0[i]),
            .m1_grant(g1[i]),
            .bus_req (breq[i]),
            .bus_wr  (bwr[i]),
            .bus_addr(baddr[i]),
            .bus_dout(bdout[i]),
            .m_din   (mdin[i])
        );
    end

    function automatic int max_hold(input int i);
        return (i == 0) ? 8 : (i == 1) ? 4 : 0;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            owner[i]    = -1;
            last[i]     = 1;
            wait_cnt[i] = 0;
        end
    endtask

    // One clock edge of the arbitration rules, using the request levels seen at the edge.
    task automatic model_step();
        int req [2];
        req[0] = int'(m0_req);
        req[1] = int'(m1_req);
        for (int i = 0; i < 3; i++) begin
            int o, nxt, mh;
            o   = owner[i];
            mh  = max_hold(i);
            nxt = o;
            if (o < 0) begin
                if (req[0] != 0 && req[1] != 0) nxt = 1 - last[i];
                else if (req[0] != 0)           nxt = 0;
                else if (req[1] != 0)           nxt = 1;
            end else if (req[o] == 0) begin
                nxt = (req[1-o] != 0) ? 1 - o : -1;
            end else if (req[1-o] != 0 && mh != 0 && wait_cnt[i] >= mh - 1) begin
                nxt = 1 - o;
            end
            if (nxt != o) begin
                if (o >= 0) last[i] = o;
                wait_cnt[i] = 0;
            end else if (o >= 0 && req[1-o] != 0) begin
                if (wait_cnt[i] < mh - 1) wait_cnt[i]++;
            end else begin
                wait_cnt[i] = 0;
            end
            owner[i] = nxt;
        end
    endtask

    task automatic check_outputs(input string phase);
        for (int i = 0; i < 3; i++) begin
            logic          e_req, e_wr;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_dout;
            e_req = 1'b0; e_wr = 1'b0; e_addr = '0; e_dout = '0;
            if (owner[i] == 0) begin
                e_req = m0_req; e_wr = m0_wr; e_addr = m0_addr; e_dout = m0_dout;
            end else if (owner[i] == 1) begin
                e_req = m1_req; e_wr = m1_wr; e_addr = m1_addr; e_dout = m1_dout;
            end
            check_val($sformatf("%s d%0d m0_grant", phase, i), 64'(g0[i]), 64'(owner[i] == 0));
            check_val($sformatf("%s d%0d m1_grant", phase, i), 64'(g1[i]), 64'(owner[i] == 1));
            check_val($sformatf("%s d%0d bus_req", phase, i), 64'(breq[i]), 64'(e_req));
            check_val($sformatf("%s d%0d bus_wr", phase, i), 64'(bwr[i]), 64'(e_wr));
            check_val($sformatf("%s d%0d bus_addr", phase, i), 64'(baddr[i]), 64'(e_addr));
            check_val($sformatf("%s d%0d bus_dout", phase, i), bdout[i], e_dout);
            check_val($sformatf("%s d%0d m_din", phase, i), mdin[i], bus_din);
        end
    endtask

    // Advance one clock: model follows the edge, then return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        else         model_reset();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        #1 check_outputs("in_reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = '0; m0_dout = '0;
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = '0; m1_dout = '0;
        bus_din = 64'h1234;
        model_reset();

        // Reset with both masters requesting, then continuous contention.
        repeat (2) @(negedge clk);
        #1 check_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_outputs("released");
        for (int k = 1; k <= 24; k++) begin
            cycle();
            #1 check_outputs("contend");
            check_val($sformatf("alt8 k%0d", k), 64'(g0[0]), 64'(((k - 1) / 8) % 2 == 0));
            check_val($sformatf("alt4 k%0d m0", k), 64'(g0[1]), 64'(((k - 1) / 4) % 2 == 0));
            check_val($sformatf("alt4 k%0d m1", k), 64'(g1[1]), 64'(((k - 1) / 4) % 2 == 1));
            check_val($sformatf("hold0 k%0d", k), 64'(g0[2]), 64'(1));
        end
        m0_req = 1'b0;
        #1 check_val("hold0 drop bus_req", 64'(breq[2]), 64'(0));
        cycle();
        #1 check_val("hold0 handover", 64'(g1[2]), 64'(1));
        check_outputs("hold0_drop");

        // Single master M1.
        m1_req = 1'b0;
        do_reset();
        m1_req = 1'b1; m1_addr = 16'h7001; m1_wr = 1'b1; m1_dout = 64'hA5;
        #1 check_outputs("single_req");
        cycle();
        #1 check_val("single m1_grant", 64'(g1[0]), 64'(1));
        check_val("single bus_addr", 64'(baddr[0]), 64'h7001);
        check_val("single bus_wr", 64'(bwr[0]), 64'(1));
        check_val("single bus_dout", bdout[0], 64'hA5);
        m1_req = 1'b0;
        #1 check_val("single drop bus_req", 64'(breq[0]), 64'(0));
        cycle();
        #1 check_val("single idle grant", 64'(g1[0]), 64'(0));
        check_val("single idle addr", 64'(baddr[0]), 64'(0));
        check_outputs("single_idle");

        // Direct handover M0 -> M1 without an idle cycle.
        m0_req = 1'b1; m0_addr = 16'h0001; m1_wr = 1'b0;
        cycle();
        m1_req = 1'b1;
        #1 check_outputs("handover_pre");
        cycle();
        m0_req = 1'b0;
        #1 check_outputs("handover_drop");
        cycle();
        #1 check_val("handover m1_grant", 64'(g1[0]), 64'(1));
        check_val("handover m0_grant", 64'(g0[0]), 64'(0));
        check_val("handover bus_addr", 64'(baddr[0]), 64'h7001);
        check_outputs("handover_post");

        // Randomised traffic with sticky requests.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) m0_req = ~m0_req;
            if ($urandom_range(3) == 0) m1_req = ~m1_req;
            m0_wr   = 1'($urandom);
            m1_wr   = 1'($urandom);
            m0_addr = AW'($urandom);
            m1_addr = AW'($urandom);
            m0_dout = {$urandom, $urandom};
            m1_dout = {$urandom, $urandom};
            bus_din = {$urandom, $urandom};
            #1 check_outputs("random");
            cycle();
        end

        // Asynchronous reset in the middle of a grant.
        m0_req = 1'b1; m1_req = 1'b0; bus_din = 64'h1234;
        cycle();
        cycle();
        #1 check_outputs("pre_async");
        reset_n = 1'b0;
        #1 check_val("async m0_grant", 64'(g0), 64'(0));
        check_val("async m1_grant", 64'(g1), 64'(0));
        check_val("async bus_req", 64'(breq), 64'(0));
        model_reset();
        check_outputs("async");
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        #1 check_outputs("post_async");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
